// File: rtl/shreg_pkg.sv
// Shared types and defaults for the shift-register load sequencer.
// Optional read-back verification is enabled by defining SHREG_VERIFY_EN.
package shreg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    SETTLE,
    DONE
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DIV   = 100_000_000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shreg_prescaler.sv
// DIV-cycle tick generator: counts while enabled, tick is high on the terminal count.
// restart forces the count back to zero and takes priority over enable.
module shreg_prescaler
  import shreg_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int PW = cnt_width(DIV);
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shreg_load_sequencer.sv
// Loads a parallel word LSB-first into an external serial-in shift register, one bit per tick.
// Define SHREG_VERIFY_EN to compare the register contents against the word at completion (err).
module shreg_load_sequencer
  import shreg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             sr_clr,
  output logic             sr_shift,
  output logic             sr_data_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_data,
  output logic             err
);

  localparam int IW = cnt_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             aborting_q, aborting_d;
  logic             in_ready_q, in_ready_d;
  logic             sr_clr_q, sr_clr_d;
  logic             sr_shift_q, sr_shift_d;
  logic             sr_data_in_q, sr_data_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic ps_restart;
  logic ps_en;
  logic tick;
  logic accept;

  assign accept = in_valid && in_ready_q;

  shreg_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (clr),
    .restart(ps_restart),
    .en     (ps_en),
    .tick   (tick)
  );

  // The CLEAR cycle doubles as the first prescaler slot so that with DIV=1
  // shifting starts immediately after the clear strobe.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    idx_d        = idx_q;
    aborting_d   = aborting_q;
    sr_shift_d   = 1'b0;
    sr_data_in_d = sr_data_in_q;
    done_d       = 1'b0;
    out_data_d   = out_data_q;
    ps_restart   = 1'b0;
    ps_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d     = in_data;
          idx_d      = '0;
          aborting_d = 1'b0;
          ps_restart = 1'b1;
          state_d    = CLEAR;
        end
      end
      CLEAR, SHIFT: begin
        if (abort) begin
          aborting_d = 1'b1;
          ps_restart = 1'b1;
          state_d    = CLEAR;
        end else if (state_q == CLEAR && aborting_q) begin
          aborting_d = 1'b0;
          state_d    = IDLE;
        end else begin
          ps_en   = 1'b1;
          state_d = SHIFT;
          if (tick) begin
            sr_shift_d   = 1'b1;
            sr_data_in_d = word_q[idx_q];
            idx_d        = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = SETTLE;
            end
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          aborting_d = 1'b1;
          ps_restart = 1'b1;
          state_d    = CLEAR;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // The last shift has landed in sr_q by now.
        out_data_d = sr_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    sr_clr_d   = (state_d == CLEAR);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      word_q       <= '0;
      idx_q        <= '0;
      aborting_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      sr_clr_q     <= 1'b1;
      sr_shift_q   <= 1'b0;
      sr_data_in_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      aborting_q   <= aborting_d;
      in_ready_q   <= in_ready_d;
      sr_clr_q     <= sr_clr_d;
      sr_shift_q   <= sr_shift_d;
      sr_data_in_q <= sr_data_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      out_data_q   <= out_data_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign sr_clr     = sr_clr_q;
  assign sr_shift   = sr_shift_q;
  assign sr_data_in = sr_data_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign out_data   = out_data_q;

`ifdef SHREG_VERIFY_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && accept) begin
      err_d = 1'b0;
    end else if (state_q == DONE) begin
      err_d = (sr_q != word_q);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
